muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameters: none; iteration count ITER = 32 (fixed, package constant).
REQ-003 clk_i  in  1  rising-edge clock, same as all pipeline registers.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  EX-stage request from the ID/EX control field; sampled only in IDLE.
REQ-006 op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i.
REQ-007 RSdata_i  in  32  operand A / dividend, from the ID/EX RS data output.
REQ-008 RTdata_i  in  32  operand B / divisor, from the ID/EX RT data output.
REQ-009 busy_o  out  1  stall request back to PC, IF/ID and ID/EX write enables.
REQ-010 done_o  out  1  one-cycle result-valid pulse.
REQ-011 hi_o  out  32  product high word / remainder.
REQ-012 lo_o  out  32  product low word / quotient.
REQ-013 divzero_o  out  1  divide-by-zero flag, valid with done_o.

Function
REQ-014 States SHALL be IDLE, RUN, FIX, DONE.
REQ-015 IDLE: start_i=1 SHALL latch op_i and absolute operand magnitudes (signed ops only), clear the 6-bit counter, and go to RUN.
REQ-016 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; after 32 steps (counter 31) go to FIX.
REQ-017 FIX SHALL apply sign correction for signed ops and go to DONE: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-018 DONE SHALL assert done_o for exactly one cycle, update hi_o/lo_o/divzero_o, and return to IDLE.
REQ-019 Latency: start sampled at edge k SHALL give done_o high in the cycle following edge k+34.
REQ-020 busy_o SHALL be 1 in RUN and FIX and 0 in IDLE and DONE, so the pipeline advances in the done_o cycle.
REQ-021 start_i SHALL be ignored outside IDLE; op_i, RSdata_i and RTdata_i are not re-sampled during an operation.
REQ-022 A divide with RTdata_i=0 SHALL skip RUN and FIX: IDLE->DONE, lo_o=0xFFFFFFFF, hi_o=dividend, divzero_o=1.
REQ-023 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_o=0x80000000, hi_o=0, divzero_o=0 (no trap).
REQ-024 All arithmetic SHALL be on 32-bit magnitudes with a 64-bit accumulator; the 32-bit two's-complement negation of 0x80000000 is itself.
REQ-025 hi_o/lo_o SHALL hold their last values until the next DONE; divzero_o SHALL clear on the next non-zero-divisor completion.

Reset
REQ-026 rst_i=1 at any edge, including mid-RUN or FIX, SHALL force IDLE, counter 0, busy_o=0, done_o=0, hi_o=0, lo_o=0, divzero_o=0, and abort any operation with no done_o.
REQ-027 start_i asserted in the same cycle as rst_i SHALL be ignored.

Structure
REQ-028 Shared package muldiv_pkg SHALL hold the op encodings, the state encoding and ITER.
REQ-029 The block SHALL be one module with no sub-module; the negate/abs helpers are package functions.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001; done_o exactly 34 cycles after the start edge; busy_o high for 33 cycles.
REQ-031 MULT -3 x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
REQ-032 DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / -1 -> lo_o=0x80000000, hi_o=0.
REQ-033 DIVU 100 / 0 -> done_o one cycle after start, divzero_o=1, lo_o=0xFFFFFFFF, hi_o=100, busy_o never high.
REQ-034 Start DIVU 100 / 7; assert rst_i at cycle 10 -> IDLE next cycle, all outputs 0, no done_o; a fresh start then yields lo_o=14, hi_o=2.
REQ-035 start_i held high throughout, with operands changed mid-RUN -> exactly one completion, using the operands latched at the first start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, the iteration count and the two's-complement helpers.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Bit 0 of the op selects signed arithmetic, bit 1 selects divide.
    function automatic logic op_is_signed(input op_t op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input op_t op);
        return op[1];
    endfunction

    // 32-bit negation; 0x80000000 maps onto itself.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // Magnitude of a signed word, returned as an unsigned 32-bit value.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start_i;
    op_t         op_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        divzero_o;

    // Pipeline side: issues requests, watches busy/done and results.
    modport master (
        output start_i, op_i, RSdata_i, RTdata_i,
        input  busy_o, done_o, hi_o, lo_o, divzero_o
    );

    // Unit side.
    modport slave (
        input  start_i, op_i, RSdata_i, RTdata_i,
        output busy_o, done_o, hi_o, lo_o, divzero_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit. One shift-add or restoring
// shift-subtract step per cycle on magnitudes held in a 64-bit accumulator,
// followed by a sign-fix cycle and a registered result/done cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    op_t         r_op;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_dz;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;
    logic        w_busy;

    logic        w_signed_req;
    logic        w_div_zero_req;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;

    // Request decode: magnitudes are only taken for signed ops.
    assign w_signed_req   = op_is_signed(bus.op_i);
    assign w_div_zero_req = op_is_div(bus.op_i) && (bus.RTdata_i == 32'd0);
    assign w_a_mag        = w_signed_req ? abs32(bus.RSdata_i) : bus.RSdata_i;
    assign w_b_mag        = w_signed_req ? abs32(bus.RTdata_i) : bus.RTdata_i;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the 65-bit {carry, acc} right by one.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Restoring divide step: the shifted partial remainder is acc[63:31];
    // a borrow (bit 32) means the trial subtract is discarded.
    assign w_div_diff = r_acc[63:31] - {1'b0, r_b};
    assign w_div_next = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and busy decode.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i)
                    w_state_next = w_div_zero_req ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == 6'(ITER - 1))
                    w_state_next = S_FIX;
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch request, iterate, sign-fix, then publish results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= 6'd0;
            r_op     <= OP_MULTU;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_dz <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_op    <= bus.op_i;
                        r_cnt   <= 6'd0;
                        r_b     <= w_b_mag;
                        r_acc   <= {32'd0, w_a_mag};
                        r_neg_q <= w_signed_req & (bus.RSdata_i[31] ^ bus.RTdata_i[31]);
                        r_neg_r <= w_signed_req & bus.RSdata_i[31];
                        if (w_div_zero_req) begin
                            r_res_lo <= 32'hFFFF_FFFF;
                            r_res_hi <= bus.RSdata_i;
                            r_res_dz <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_res_dz <= 1'b0;
                    if (op_is_div(r_op)) begin
                        r_res_lo <= r_neg_q ? neg32(r_acc[31:0])  : r_acc[31:0];
                        r_res_hi <= r_neg_r ? neg32(r_acc[63:32]) : r_acc[63:32];
                    end else begin
                        {r_res_hi, r_res_lo} <= r_neg_q ? neg64(r_acc) : r_acc;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_hi   <= r_res_hi;
                    r_lo   <= r_res_lo;
                    r_dz   <= r_res_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = w_busy;
    assign bus.done_o    = r_done;
    assign bus.hi_o      = r_hi;
    assign bus.lo_o      = r_lo;
    assign bus.divzero_o = r_dz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fixed vectors with hand-computed results,
// latency/busy counts, divide-by-zero, reset abort and held-start behaviour.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done_o. cycles counts edges
    // from the start-sampling edge to the edge after which done_o is seen.
    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int busy_cycles, output logic seen,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.op_i     = op;
        bus.RSdata_i = a;
        bus.RTdata_i = b;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        busy_cycles  = bus.busy_o ? 1 : 0;
        cycles       = 0;
        seen         = 1'b0;
        while (cycles < 100 && !seen) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.done_o) seen = 1'b1;
            else if (bus.busy_o) busy_cycles++;
        end
        hi = bus.hi_o;
        lo = bus.lo_o;
        dz = bus.divzero_o;
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0b cycles=%0d busy=%0d",
                 op, a, b, hi, lo, dz, cycles, busy_cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vec_cnt++;
        if ({bus.busy_o, bus.done_o, bus.divzero_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%0b done=%0b dz=%0b hi=%08h lo=%08h, required all 0",
                     bus.busy_o, bus.done_o, bus.divzero_o, bus.hi_o, bus.lo_o);
        end
        $display("reset applied");
    endtask

    task automatic test_multu();
        int c, bc; logic s; logic [31:0] hi, lo; logic dz;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || c !== 34) begin
            err_cnt++;
            $display("FAIL multu_latency: seen=%0b cycles=%0d, required 1/34", s, c);
        end
        vec_cnt++;
        if (bc !== 33) begin
            err_cnt++;
            $display("FAIL multu_busy: %0d busy cycles, required 33", bc);
        end
        vec_cnt++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || dz !== 1'b0) begin
            err_cnt++;
            $display("FAIL multu_result: hi=%08h lo=%08h dz=%0b, required FFFFFFFE/00000001/0", hi, lo, dz);
        end
    endtask

    task automatic test_mult();
        int c, bc; logic s; logic [31:0] hi, lo; logic dz;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            err_cnt++;
            $display("FAIL mult_neg3x5: seen=%0b hi=%08h lo=%08h, required 1/FFFFFFFF/FFFFFFF1", s, hi, lo);
        end
    endtask

    task automatic test_div_signed();
        int c, bc; logic s; logic [31:0] hi, lo; logic dz;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || dz !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_neg7by2: seen=%0b lo=%08h hi=%08h dz=%0b, required 1/FFFFFFFD/FFFFFFFF/0", s, lo, hi, dz);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || lo !== 32'h8000_0000 || hi !== 32'd0 || dz !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_min_by_m1: seen=%0b lo=%08h hi=%08h dz=%0b, required 1/80000000/0/0", s, lo, hi, dz);
        end
    endtask

    task automatic test_divzero();
        int c, bc; logic s; logic [31:0] hi, lo; logic dz;
        run_op(OP_DIVU, 32'd100, 32'd0, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || c !== 1 || bc !== 0) begin
            err_cnt++;
            $display("FAIL divzero_timing: seen=%0b cycles=%0d busy=%0d, required 1/1/0", s, c, bc);
        end
        vec_cnt++;
        if (dz !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd100) begin
            err_cnt++;
            $display("FAIL divzero_result: dz=%0b lo=%08h hi=%08h, required 1/FFFFFFFF/00000064", dz, lo, hi);
        end
        // A following good divide must clear the flag.
        run_op(OP_DIVU, 32'd100, 32'd7, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || dz !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            err_cnt++;
            $display("FAIL divu_after_dz: seen=%0b dz=%0b lo=%08h hi=%08h, required 1/0/0000000E/00000002", s, dz, lo, hi);
        end
    endtask

    task automatic test_reset_mid_run();
        int c, bc, dones; logic s; logic [31:0] hi, lo; logic dz;
        dones = 0;
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.op_i     = OP_DIVU;
        bus.RSdata_i = 32'd100;
        bus.RTdata_i = 32'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) dones++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec_cnt++;
        if ({bus.busy_o, bus.done_o, bus.divzero_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_run: busy=%0b done=%0b dz=%0b hi=%08h lo=%08h, required all 0",
                     bus.busy_o, bus.done_o, bus.divzero_o, bus.hi_o, bus.lo_o);
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.done_o || bus.busy_o) dones++;
        end
        vec_cnt++;
        if (dones !== 0) begin
            err_cnt++;
            $display("FAIL reset_abort: %0d done/busy cycles after abort, required 0", dones);
        end
        $display("reset mid-run applied");
        run_op(OP_DIVU, 32'd100, 32'd7, c, bc, s, hi, lo, dz);
        vec_cnt++;
        if (s !== 1'b1 || lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
            err_cnt++;
            $display("FAIL divu_after_reset: seen=%0b lo=%08h hi=%08h dz=%0b, required 1/0000000E/00000002/0", s, lo, hi, dz);
        end
    endtask

    task automatic test_start_in_reset();
        int busy_seen;
        busy_seen = 0;
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.start_i  = 1'b1;
        bus.op_i     = OP_MULTU;
        bus.RSdata_i = 32'd3;
        bus.RTdata_i = 32'd4;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.busy_o || bus.done_o) busy_seen++;
        end
        vec_cnt++;
        if (busy_seen !== 0) begin
            err_cnt++;
            $display("FAIL start_during_reset: %0d active cycles, required 0", busy_seen);
        end
        $display("start with reset applied");
    endtask

    task automatic test_back_to_back();
        int n, dones; logic [31:0] hi, lo;
        n = 0; dones = 0; hi = 32'd0; lo = 32'd0;
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.op_i     = OP_DIVU;
        bus.RSdata_i = 32'd100;
        bus.RTdata_i = 32'd7;
        while (n < 100 && dones == 0) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                bus.RSdata_i = 32'd1000;
                bus.RTdata_i = 32'd3;
                bus.op_i     = OP_MULTU;
            end
            if (bus.done_o) begin
                dones++;
                hi = bus.hi_o;
                lo = bus.lo_o;
                bus.start_i = 1'b0;
            end
        end
        bus.start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) dones++;
        end
        $display("held start: dones=%0d hi=%08h lo=%08h cycles=%0d", dones, hi, lo, n);
        vec_cnt++;
        if (dones !== 1) begin
            err_cnt++;
            $display("FAIL held_start_count: %0d completions, required 1", dones);
        end
        vec_cnt++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            err_cnt++;
            $display("FAIL held_start_operands: lo=%08h hi=%08h, required 0000000E/00000002", lo, hi);
        end
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.op_i     = OP_MULTU;
        bus.RSdata_i = 32'd0;
        bus.RTdata_i = 32'd0;
        test_reset();
        test_multu();
        test_mult();
        test_div_signed();
        test_divzero();
        test_reset_mid_run();
        test_start_in_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
